// File: rtl/if_stage_pkg.sv
// if_stage shared types: reset defaults, next-PC select encoding,
// and the IF/ID pipeline register bundle.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard controls, IM port, D-stage redirects, IF/ID outs.
// master = fetch stage, slave = surrounding pipeline / IM / hazard unit.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] instr_F;
  logic        br_take_D;
  logic        jump_D;
  logic        jr_D;
  logic [15:0] imm16_D;
  logic [25:0] index26_D;
  logic [31:0] rs_data_D;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        valid_D;

  modport master (
    input  stall, flush, instr_F,
    input  br_take_D, jump_D, jr_D,
    input  imm16_D, index26_D, rs_data_D,
    output pc_F, instr_D, pc_D, pc8_D,
    output valid_D
  );

  modport slave (
    output stall, flush, instr_F,
    output br_take_D, jump_D, jr_D,
    output imm16_D, index26_D, rs_data_D,
    input  pc_F, instr_D, pc_D, pc8_D,
    input  valid_D
  );
endinterface

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC: jr > j/jal > taken beq > pc_F+4.
// Branch/jump targets are relative to pc_D+4 (delay slot address).
module npc_calc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic        br_take,
  input  logic        jump,
  input  logic        jr,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_data,
  output logic [31:0] npc
);

  logic [31:0] pc4_d;
  logic [31:0] br_off;
  npc_sel_e    sel;

  assign pc4_d  = pc_d + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Redirects may overlap (jr with jump), so encode priority first.
  always_comb begin
    sel = NPC_SEQ;
    if (jr)           sel = NPC_JR;
    else if (jump)    sel = NPC_J;
    else if (br_take) sel = NPC_BR;
  end

  always_comb begin
    npc = pc_f + 32'd4;
    unique case (sel)
      NPC_JR:  npc = rs_data;
      NPC_J:   npc = {pc4_d[31:28], index26, 2'b00};
      NPC_BR:  npc = pc4_d + br_off;
      NPC_SEQ: npc = pc_f + 32'd4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, next-PC select and IF/ID register.
// Ports: clk, reset (sync, high), bus (if_stage_if.master).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] npc;
  if_id_t      ifid_q;

  npc_calc u_npc (
    .pc_f    (pc_q),
    .pc_d    (ifid_q.pc),
    .br_take (bus.br_take_D),
    .jump    (bus.jump_D),
    .jr      (bus.jr_D),
    .imm16   (bus.imm16_D),
    .index26 (bus.index26_D),
    .rs_data (bus.rs_data_D),
    .npc     (npc)
  );

  // Stall freezes everything (redirects retried next cycle);
  // flush only bubbles IF/ID, the PC still advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc    <= '0;
      ifid_q.pc8   <= '0;
      ifid_q.valid <= 1'b0;
    end else if (!bus.stall) begin
      pc_q <= npc;
      if (bus.flush) begin
        ifid_q.instr <= NOP_INSTR;
        ifid_q.pc    <= '0;
        ifid_q.pc8   <= '0;
        ifid_q.valid <= 1'b0;
      end else begin
        ifid_q.instr <= bus.instr_F;
        ifid_q.pc    <= pc_q;
        ifid_q.pc8   <= pc_q + 32'd8;
        ifid_q.valid <= 1'b1;
      end
    end
  end

  assign bus.pc_F    = pc_q;
  assign bus.instr_D = ifid_q.instr;
  assign bus.pc_D    = ifid_q.pc;
  assign bus.pc8_D   = ifid_q.pc8;
  assign bus.valid_D = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed cycles push expected
// IF/ID + PC state; a negedge monitor pops and compares.
module tb_if_stage;
  import if_stage_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pcd;
    logic [31:0] pc8;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h3C01_0001;
    return {16'hA000, a[15:0]};
  endfunction

  always_comb bus.instr_F = im(bus.pc_F);

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".pc_F"},    bus.pc_F,    e.pc);
      chk({e.tag, ".instr_D"}, bus.instr_D, e.ins);
      chk({e.tag, ".pc_D"},    bus.pc_D,    e.pcd);
      chk({e.tag, ".pc8_D"},   bus.pc8_D,   e.pc8);
      chk({e.tag, ".valid_D"}, {31'd0, bus.valid_D}, {31'd0, e.v});
    end
  end

  // One clock: drive inputs, take the edge, queue the expected state.
  task automatic cyc(
    input string       tag,
    input logic        rst, st, fl, br, j, jr,
    input logic [15:0] imm,
    input logic [25:0] idx,
    input logic [31:0] rs,
    input logic [31:0] pc, ins, pcd, pc8,
    input logic        v
  );
    exp_t e;
    reset         = rst;
    bus.stall     = st;
    bus.flush     = fl;
    bus.br_take_D = br;
    bus.jump_D    = j;
    bus.jr_D      = jr;
    bus.imm16_D   = imm;
    bus.index26_D = idx;
    bus.rs_data_D = rs;
    @(posedge clk);
    e.tag = tag; e.pc = pc; e.ins = ins;
    e.pcd = pcd; e.pc8 = pc8; e.v = v;
    q.push_back(e);
    #1;
  endtask

  task automatic seq(input string tag,
                     input logic [31:0] pc, pcd);
    cyc(tag, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0,
        pc, im(pcd), pcd, pcd + 32'd8, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 0; bus.flush = 0;
    bus.br_take_D = 0; bus.jump_D = 0; bus.jr_D = 0;
    bus.imm16_D = 0; bus.index26_D = 0; bus.rs_data_D = 0;

    cyc("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h3000, 32'h0, 32'h0, 32'h0, 0);
    cyc("rst1", 1, 1, 1, 1, 1, 1, 16'h1, 26'h1, 32'h5,
        32'h3000, 32'h0, 32'h0, 32'h0, 0);
    cyc("rel", 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h3004, 32'h3C01_0001, 32'h3000, 32'h3008, 1);
    seq("seq1", 32'h3008, 32'h3004);
    seq("seq2", 32'h300C, 32'h3008);
    cyc("beq", 0, 0, 0, 1, 0, 0, 16'hFFFE, 0, 0,
        32'h3004, im(32'h300C), 32'h300C, 32'h3014, 1);
    seq("s3", 32'h3008, 32'h3004);
    seq("s4", 32'h300C, 32'h3008);
    seq("s5", 32'h3010, 32'h300C);
    seq("jal_in_d", 32'h3014, 32'h3010);
    cyc("jal", 0, 0, 0, 0, 1, 0, 0, 26'h0000C40, 0,
        32'h3100, im(32'h3014), 32'h3014, 32'h301C, 1);
    cyc("jr_pri", 0, 0, 0, 1, 1, 1, 16'h0010, 26'h0000C40,
        32'h3020, 32'h3020, im(32'h3100), 32'h3100, 32'h3108, 1);
    for (int i = 0; i < 3; i++)
      cyc("stall", 0, 1, 0, 1, 0, 0, 16'h0004, 0, 0,
          32'h3020, im(32'h3100), 32'h3100, 32'h3108, 1);
    cyc("br_after", 0, 0, 0, 1, 0, 0, 16'h0004, 0, 0,
        32'h3114, im(32'h3020), 32'h3020, 32'h3028, 1);
    cyc("flush", 0, 0, 1, 0, 0, 0, 0, 0, 0,
        32'h3118, 32'h0, 32'h0, 32'h0, 0);
    seq("post_fl", 32'h311C, 32'h3118);
    cyc("fl_st", 0, 1, 1, 0, 0, 0, 0, 0, 0,
        32'h311C, im(32'h3118), 32'h3118, 32'h3120, 1);
    cyc("rst_st", 1, 1, 0, 0, 0, 0, 0, 0, 0,
        32'h3000, 32'h0, 32'h0, 32'h0, 0);
    cyc("rel2", 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h3004, 32'h3C01_0001, 32'h3000, 32'h3008, 1);
    cyc("jr_mis", 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE,
        32'hFFFF_FFFE, im(32'h3004), 32'h3004, 32'h300C, 1);
    seq("wrap", 32'h0000_0002, 32'hFFFF_FFFE);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
